// File: rtl/snake_renderer_if.sv
// Segment-RAM read bus between the renderer (master) and the snake body RAM (slave).
// Read data is valid exactly one clock after the address is presented.
interface snake_renderer_if;
  logic [5:0]  oSeg_Addr;
  logic [10:0] iSeg_Data;

  modport master (output oSeg_Addr, input iSeg_Data);
  modport slave  (input oSeg_Addr, output iSeg_Data);
endinterface

// File: rtl/snake_renderer.sv
// Snake game pixel renderer: scans the segment RAM once per line into a shadow row mask,
// swaps it into the active mask at the next line start and colours pixels combinationally.
module snake_renderer (
  input  logic        iCLK,
  input  logic        reset,
  input  logic        iHS,
  input  logic        iVS,
  input  logic [9:0]  iCurrent_X,
  input  logic [9:0]  iCurrent_Y,
  snake_renderer_if.master segBus,
  input  logic [6:0]  iLength,
  input  logic [5:0]  iFood_Col,
  input  logic [4:0]  iFood_Row,
  input  logic        iGame_Over,
  output logic        oRed,
  output logic        oGreen,
  output logic        oBlue,
  output logic        oBusy
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} ScanState;

  ScanState    state;
  logic        hsQ, vsQ;
  logic        lineStart, frameStart;
  logic [6:0]  lenLatch;
  logic [5:0]  foodCol;
  logic [4:0]  foodRow;
  logic        gameOver;
  logic [39:0] activeMask, shadowMask;
  logic [5:0]  activeHeadCol, shadowHeadCol;
  logic        activeHeadValid, shadowHeadValid;
  logic [4:0]  targetRow;
  logic [5:0]  segAddr;
  logic        rdValid, rdFirst;
  logic [9:0]  nextY;
  logic [5:0]  segCol, pixCol;
  logic [4:0]  segRow, pixRow;
  logic        segHit, bodyHit;
  logic        unusedBits;

  assign lineStart  = iHS & ~hsQ;
  assign frameStart = vsQ & ~iVS;

  // The scan prepares the row that will be displayed on the following line.
  assign nextY  = (iCurrent_Y >= 10'd479) ? 10'd0 : iCurrent_Y + 10'd1;
  assign segCol = segBus.iSeg_Data[10:5];
  assign segRow = segBus.iSeg_Data[4:0];
  assign segHit = rdValid && (segRow == targetRow) && (segCol < 6'd40) && (segRow < 5'd30);

  assign pixCol  = iCurrent_X[9:4];
  assign pixRow  = iCurrent_Y[8:4];
  assign bodyHit = (pixCol < 6'd40) && activeMask[pixCol];

  assign unusedBits = ^{iCurrent_X[3:0], iCurrent_Y[9], iCurrent_Y[3:0], nextY[9], nextY[3:0]};

  assign segBus.oSeg_Addr = segAddr;
  assign oBusy            = (state != IDLE);

  // Sync edge detectors and per-frame parameter latches.
  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      hsQ      <= 1'b1;
      vsQ      <= 1'b1;
      lenLatch <= 7'd0;
      foodCol  <= 6'd0;
      foodRow  <= 5'd0;
      gameOver <= 1'b0;
    end else begin
      hsQ <= iHS;
      vsQ <= iVS;
      if (frameStart) begin
        lenLatch <= (iLength > 7'd64) ? 7'd64 : iLength;
        foodCol  <= iFood_Col;
        foodRow  <= iFood_Row;
        gameOver <= iGame_Over;
      end
    end
  end

  // Scan FSM; a line start always wins, discarding any read still in flight.
  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      segAddr         <= 6'd0;
      rdValid         <= 1'b0;
      rdFirst         <= 1'b0;
      activeMask      <= 40'd0;
      shadowMask      <= 40'd0;
      activeHeadCol   <= 6'd0;
      shadowHeadCol   <= 6'd0;
      activeHeadValid <= 1'b0;
      shadowHeadValid <= 1'b0;
      targetRow       <= 5'd0;
    end else if (lineStart) begin
      activeMask      <= shadowMask;
      activeHeadCol   <= shadowHeadCol;
      activeHeadValid <= shadowHeadValid;
      shadowMask      <= 40'd0;
      shadowHeadCol   <= 6'd0;
      shadowHeadValid <= 1'b0;
      targetRow       <= nextY[8:4];
      segAddr         <= 6'd0;
      rdValid         <= 1'b0;
      rdFirst         <= 1'b0;
      state           <= (lenLatch == 7'd0) ? IDLE : SCAN;
    end else begin
      rdValid <= (state == SCAN);
      rdFirst <= (state == SCAN) && (segAddr == 6'd0);
      if (segHit) begin
        shadowMask[segCol] <= 1'b1;
        if (rdFirst) begin
          shadowHeadCol   <= segCol;
          shadowHeadValid <= 1'b1;
        end
      end
      case (state)
        IDLE: segAddr <= 6'd0;
        SCAN: begin
          // Compare with >= so a frame-start length change mid-scan cannot run away.
          if (({1'b0, segAddr} + 7'd1) >= lenLatch) begin
            state   <= DRAIN;
            segAddr <= 6'd0;
          end else begin
            segAddr <= segAddr + 6'd1;
          end
        end
        DRAIN: begin
          state   <= IDLE;
          segAddr <= 6'd0;
        end
        default: begin
          state   <= IDLE;
          segAddr <= 6'd0;
        end
      endcase
    end
  end

  // Pixel colour, priority head > body > food > border.
  always_comb begin
    oRed   = 1'b0;
    oGreen = 1'b0;
    oBlue  = 1'b0;
    if (!reset) begin
      if (activeHeadValid && (pixCol == activeHeadCol)) begin
        oRed   = 1'b1;
        oGreen = 1'b1;
        oBlue  = 1'b1;
      end else if (bodyHit) begin
        oRed   = gameOver;
        oGreen = ~gameOver;
      end else if ((pixCol == foodCol) && (pixRow == foodRow)) begin
        oRed = 1'b1;
      end else if ((pixCol == 6'd0) || (pixCol == 6'd39) || (pixRow == 5'd0) || (pixRow == 5'd29)) begin
        oBlue = 1'b1;
      end
    end
  end

endmodule
